// File: rtl/execute_stage_mc.sv
// MIPS execute stage with valid/ready handshake and a registered EX/MEM output.
// Define MULDIV_EN to build the iterative signed MULT/DIV unit with HI/LO registers.
module execute_stage_mc #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SHAMT_W    = $clog2(DATA_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     read_data1,
  input  logic [DATA_W-1:0]     read_data2,
  input  logic [DATA_W-1:0]     immediate,
  input  logic [5:0]            funct,
  input  logic [2:0]            alu_op,
  input  logic                  alu_src,
  input  logic                  reg_dst,
  input  logic [DATA_W-1:0]     last_pc,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     alu_result,
  output logic                  zero,
  output logic [DATA_W-1:0]     branch_target,
  output logic [DATA_W-1:0]     read_data2_out,
  output logic [REG_ADDR_W-1:0] dest_reg,
  output logic                  busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]               state;
  logic                     accept, start_md, out_free;
  logic signed [DATA_W-1:0] op1, op2;
  logic [SHAMT_W-1:0]       shamt;
  logic [DATA_W-1:0]        alu_res;

  logic                     vld_p1, zero_p1;
  logic [DATA_W-1:0]        alu_result_p1, branch_target_p1, rd2_p1;
  logic [REG_ADDR_W-1:0]    dest_reg_p1;

  function automatic logic [DATA_W-1:0] slt_f(input logic signed [DATA_W-1:0] x,
                                               input logic signed [DATA_W-1:0] y);
    return {{(DATA_W-1){1'b0}}, (x < y)};
  endfunction

  assign out_free = !vld_p1 || out_ready;
  assign in_ready = (state == IDLE) && out_free;
  assign accept   = in_valid && in_ready;
  assign op1      = read_data1;
  assign op2      = alu_src ? immediate : read_data2;
  assign shamt    = immediate[6 +: SHAMT_W];

`ifdef MULDIV_EN
  localparam logic [1:0] MUL = 2'd1;
  localparam logic [1:0] DIV = 2'd2;
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);

  logic [DATA_W-1:0]   hi_q, lo_q, acc_q, mq_q, mag_b_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                neg_q_q, neg_r_q, is_mul, is_div;
  logic [DATA_W:0]     add_sum, div_shift, div_diff;
  logic [2*DATA_W-1:0] prod_mag;

  function automatic logic [DATA_W-1:0] mag_f(input logic signed [DATA_W-1:0] x);
    return (x < 0) ? -x : x;
  endfunction

  assign is_mul    = (alu_op == 3'b010) && (funct == 6'h18);
  assign is_div    = (alu_op == 3'b010) && (funct == 6'h1A);
  assign start_md  = accept && (is_mul || is_div);
  assign busy      = (state == MUL) || (state == DIV);
  assign add_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mag_b_q} : '0);
  assign div_shift = {acc_q, mq_q[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, mag_b_q};
  assign prod_mag  = {acc_q, mq_q};

  // Sequencer: one extra cycle after the last iteration applies the sign correction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        IDLE: if (start_md) begin
          cnt_q <= '0;
          if (is_div && read_data2 == '0) begin
            lo_q  <= '1;
            hi_q  <= read_data1;
            state <= DONE;
          end else begin
            state <= is_mul ? MUL : DIV;
          end
        end
        MUL, DIV: if (cnt_q == LAST) begin
          state <= DONE;
          if (state == MUL) begin
            {hi_q, lo_q} <= neg_q_q ? -prod_mag : prod_mag;
          end else begin
            lo_q <= neg_q_q ? -mq_q : mq_q;
            hi_q <= neg_r_q ? -acc_q : acc_q;
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        DONE: if (out_free) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Iteration datapath: shift-add multiply / restoring divide on magnitudes.
  always_ff @(posedge clk) begin
    if (start_md) begin
      acc_q   <= '0;
      mq_q    <= mag_f(read_data1);
      mag_b_q <= mag_f(read_data2);
      neg_q_q <= read_data1[DATA_W-1] ^ read_data2[DATA_W-1];
      neg_r_q <= read_data1[DATA_W-1];
    end else if (state == MUL && cnt_q != LAST) begin
      acc_q <= add_sum[DATA_W:1];
      mq_q  <= {add_sum[0], mq_q[DATA_W-1:1]};
    end else if (state == DIV && cnt_q != LAST) begin
      if (!div_diff[DATA_W]) begin
        acc_q <= div_diff[DATA_W-1:0];
        mq_q  <= {mq_q[DATA_W-2:0], 1'b1};
      end else begin
        acc_q <= div_shift[DATA_W-1:0];
        mq_q  <= {mq_q[DATA_W-2:0], 1'b0};
      end
    end
  end
`else
  assign state    = IDLE;
  assign start_md = 1'b0;
  assign busy     = 1'b0;
`endif

  always_comb begin
    alu_res = '0;
    case (alu_op)
      3'b001: alu_res = op1 - op2;
      3'b010: begin
        case (funct)
          6'h20:   alu_res = op1 + op2;
          6'h22:   alu_res = op1 - op2;
          6'h24:   alu_res = op1 & op2;
          6'h25:   alu_res = op1 | op2;
          6'h27:   alu_res = ~(op1 | op2);
          6'h2A:   alu_res = slt_f(op1, op2);
          6'h00:   alu_res = op2 << shamt;
          6'h02:   alu_res = op2 >> shamt;
          6'h03:   alu_res = op2 >>> shamt;
`ifdef MULDIV_EN
          6'h10:   alu_res = hi_q;
          6'h12:   alu_res = lo_q;
`endif
          default: alu_res = '0;
        endcase
      end
      3'b011: alu_res = op1 & op2;
      3'b100: alu_res = op1 | op2;
      3'b101: alu_res = slt_f(op1, op2);
      default: alu_res = op1 + op2;
    endcase
  end

  // EX/MEM output register (p1); a finished MULT/DIV emits a zero-result token.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1           <= 1'b0;
      alu_result_p1    <= '0;
      zero_p1          <= 1'b0;
      branch_target_p1 <= '0;
      rd2_p1           <= '0;
      dest_reg_p1      <= '0;
    end else if (accept && !start_md) begin
      vld_p1           <= 1'b1;
      alu_result_p1    <= alu_res;
      zero_p1          <= (alu_res == '0);
      branch_target_p1 <= last_pc + (immediate << 2);
      rd2_p1           <= read_data2;
      dest_reg_p1      <= reg_dst ? rd : rt;
    end else if (state == DONE && out_free) begin
      vld_p1           <= 1'b1;
      alu_result_p1    <= '0;
      zero_p1          <= 1'b1;
      branch_target_p1 <= '0;
      rd2_p1           <= '0;
      dest_reg_p1      <= '0;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid      = vld_p1;
  assign alu_result     = alu_result_p1;
  assign zero           = zero_p1;
  assign branch_target  = branch_target_p1;
  assign read_data2_out = rd2_p1;
  assign dest_reg       = dest_reg_p1;

endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed bench for execute_stage_mc; follows the MULDIV_EN build selection of the RTL.
module tb_execute_stage_mc;
  localparam int DATA_W = 32;
  localparam int REG_ADDR_W = 5;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, alu_src, reg_dst, out_valid, out_ready, zero, busy;
  logic [DATA_W-1:0] read_data1, read_data2, immediate, last_pc;
  logic [DATA_W-1:0] alu_result, branch_target, read_data2_out;
  logic [5:0] funct;
  logic [2:0] alu_op;
  logic [REG_ADDR_W-1:0] rt, rd, dest_reg;

  int errors = 0;
  int checks = 0;
  int lowcnt;

  always #5 clk = ~clk;

  execute_stage_mc #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .read_data1(read_data1), .read_data2(read_data2), .immediate(immediate),
    .funct(funct), .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst),
    .last_pc(last_pc), .rt(rt), .rd(rd), .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .zero(zero), .branch_target(branch_target),
    .read_data2_out(read_data2_out), .dest_reg(dest_reg), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic src);
    in_valid = 1'b1; alu_op = op; funct = fn;
    read_data1 = a; read_data2 = b; immediate = imm; alu_src = src;
  endtask

  task automatic op_check(input string tag, input logic [2:0] op, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                          input logic src, input logic [31:0] exp);
    drive(op, fn, a, b, imm, src);
    step();
    chk({tag, "_vld"}, out_valid, 1);
    chk(tag, alu_result, exp);
  endtask

  task automatic wait_ready(input int limit);
    lowcnt = 0;
    while (!in_ready && lowcnt < limit) begin
      lowcnt++;
      step();
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    read_data1 = '0; read_data2 = '0; immediate = '0; last_pc = '0;
    funct = '0; alu_op = '0; alu_src = 1'b0; reg_dst = 1'b0; rt = '0; rd = '0;
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_result", alu_result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_dest", dest_reg, 0);
    chk("rst_branch", branch_target, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // R-type add into rd
    reg_dst = 1'b1; rd = 5'd3; rt = 5'd9;
    drive(3'b010, 6'h20, 32'd5, 32'd7, 32'd0, 1'b0);
    step();
    chk("add_vld", out_valid, 1);
    chk("add_res", alu_result, 12);
    chk("add_zero", zero, 0);
    chk("add_dest", dest_reg, 3);
    chk("add_rd2", read_data2_out, 7);

    // sub giving zero, negative branch offset, rt destination
    reg_dst = 1'b0; rt = 5'd4; last_pc = 32'h100;
    drive(3'b001, 6'h00, 32'h1234, 32'h1234, 32'hFFFF_FFFF, 1'b0);
    step();
    chk("sub_res", alu_result, 0);
    chk("sub_zero", zero, 1);
    chk("sub_branch", branch_target, 32'hFC);
    chk("sub_dest", dest_reg, 4);
    chk("sub_rd2", read_data2_out, 32'h1234);

    op_check("and",   3'b010, 6'h24, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, 32'hF000);
    op_check("or",    3'b010, 6'h25, 32'hF0F0, 32'h0F00, 32'd0, 1'b0, 32'hFFF0);
    op_check("nor",   3'b010, 6'h27, 32'd0, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF);
    op_check("slt_t", 3'b010, 6'h2A, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd1);
    op_check("slt_f", 3'b010, 6'h2A, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd0);
    op_check("sll",   3'b010, 6'h00, 32'd0, 32'd1, 32'h100, 1'b0, 32'h10);
    op_check("srl",   3'b010, 6'h02, 32'd0, 32'h8000_0000, 32'h100, 1'b0, 32'h0800_0000);
    op_check("sra",   3'b010, 6'h03, 32'd0, 32'h8000_0000, 32'h100, 1'b0, 32'hF800_0000);
    op_check("sub_wrap", 3'b010, 6'h22, 32'd0, 32'd1, 32'd0, 1'b0, 32'hFFFF_FFFF);
    op_check("addi",  3'b000, 6'h00, 32'd10, 32'd99, 32'hFFFF_FFFE, 1'b1, 32'd8);
    op_check("andi",  3'b011, 6'h00, 32'hFF, 32'd0, 32'h0F, 1'b1, 32'h0F);
    op_check("ori",   3'b100, 6'h00, 32'hF0, 32'd0, 32'h0F, 1'b1, 32'hFF);
    op_check("slti",  3'b101, 6'h00, 32'hFFFF_FFFB, 32'd0, 32'd3, 1'b1, 32'd1);
    op_check("op110", 3'b110, 6'h00, 32'd4, 32'd6, 32'd0, 1'b0, 32'd10);
    op_check("badfn", 3'b010, 6'h3F, 32'd4, 32'd6, 32'd0, 1'b0, 32'd0);
    chk("badfn_zero", zero, 1);

    // Output stall: three blocked cycles, then one result per cycle
    op_check("st_a", 3'b010, 6'h20, 32'd1, 32'd1, 32'd0, 1'b0, 32'd2);
    out_ready = 1'b0;
    drive(3'b010, 6'h20, 32'd2, 32'd2, 32'd0, 1'b0);
    #1;
    chk("st_in_ready0", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_hold_vld", out_valid, 1);
      chk("st_hold_res", alu_result, 2);
      chk("st_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("st_release", in_ready, 1);
    step();
    chk("st_b", alu_result, 4);
    op_check("st_c", 3'b010, 6'h20, 32'd3, 32'd3, 32'd0, 1'b0, 32'd6);
    in_valid = 1'b0;
    step();
    chk("st_drain", out_valid, 0);

`ifdef MULDIV_EN
    // mult -3 * 7 followed by mflo/mfhi
    drive(3'b010, 6'h18, 32'hFFFF_FFFD, 32'd7, 32'd0, 1'b0);
    step();
    chk("mul_busy", busy, 1);
    drive(3'b010, 6'h12, 32'd0, 32'd0, 32'd0, 1'b0);
    wait_ready(100);
    chk("mul_lat", lowcnt, 34);
    chk("mul_tok_vld", out_valid, 1);
    chk("mul_tok_zero", zero, 1);
    chk("mul_tok_res", alu_result, 0);
    chk("mul_busy0", busy, 0);
    step();
    chk("mflo", alu_result, 32'hFFFF_FFEB);
    op_check("mfhi", 3'b010, 6'h10, 32'd0, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF);

    // div -7 / 2
    drive(3'b010, 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0);
    step();
    drive(3'b010, 6'h12, 32'd0, 32'd0, 32'd0, 1'b0);
    wait_ready(100);
    chk("div_lat", lowcnt, 34);
    step();
    chk("div_lo", alu_result, 32'hFFFF_FFFD);
    op_check("div_hi", 3'b010, 6'h10, 32'd0, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF);

    // divide by zero
    drive(3'b010, 6'h1A, 32'd9, 32'd0, 32'd0, 1'b0);
    step();
    drive(3'b010, 6'h12, 32'd0, 32'd0, 32'd0, 1'b0);
    wait_ready(100);
    chk("dz_lat", lowcnt, 1);
    chk("dz_tok", out_valid, 1);
    step();
    chk("dz_lo", alu_result, 32'hFFFF_FFFF);
    op_check("dz_hi", 3'b010, 6'h10, 32'd0, 32'd0, 32'd0, 1'b0, 32'd9);

    // reset during a multiply
    drive(3'b010, 6'h18, 32'd5, 32'd5, 32'd0, 1'b0);
    step();
    in_valid = 1'b0;
    repeat (10) step();
    chk("mr_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("mr_vld", out_valid, 0);
    chk("mr_res", alu_result, 0);
    chk("mr_rd2", read_data2_out, 0);
    chk("mr_busy", busy, 0);
    step();
    rst = 1'b0;
    #1;
    chk("mr_in_ready", in_ready, 1);
    op_check("mr_hi", 3'b010, 6'h10, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    op_check("mr_lo", 3'b010, 6'h12, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    chk("mr_lo_zero", zero, 1);
`else
    // without the MULT/DIV unit these functs are single-cycle and return 0
    op_check("nomul", 3'b010, 6'h18, 32'hFFFF_FFFD, 32'd7, 32'd0, 1'b0, 32'd0);
    chk("nomul_busy", busy, 0);
    chk("nomul_ready", in_ready, 1);
    op_check("nodiv", 3'b010, 6'h1A, 32'd9, 32'd3, 32'd0, 1'b0, 32'd0);
    op_check("nomfhi", 3'b010, 6'h10, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    op_check("nomflo", 3'b010, 6'h12, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    chk("nomflo_zero", zero, 1);
`endif

    in_valid = 1'b0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/execute_stage_mc.md
Name: execute_stage_mc

Overview:
- Parametrised, registered execute stage for the MIPS pipeline; sits between the ID/EX and EX/MEM pipeline registers.
- Selects the ALU operand, decodes ALU control, computes the ALU result, zero flag, branch target and destination register.
- Adds a valid/ready handshake on both sides and an iterative multi-cycle MULT/DIV unit writing HI/LO (optional build feature).
- A stall on the input side blocks issue; a stall on the output side holds the result.

Parameters:
- DATA_W, 32, datapath width; must be a power of 2 and at least 8.
- REG_ADDR_W, 5, register-file address width.
- SHAMT_W, $clog2(DATA_W), shift-amount width, taken from immediate[6 +: SHAMT_W].

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ID/EX presents an instruction.
- in_ready  out  1  stage accepts an instruction this cycle.
- read_data1  in  DATA_W  rs operand.
- read_data2  in  DATA_W  rt operand.
- immediate  in  DATA_W  sign-extended immediate.
- funct  in  6  R-type function field.
- alu_op  in  3  main-control ALU operation class.
- alu_src  in  1  0 selects read_data2, 1 selects immediate as ALU input 2.
- reg_dst  in  1  0 selects rt, 1 selects rd as destination.
- last_pc  in  DATA_W  PC+4 of the instruction.
- rt  in  REG_ADDR_W  rt field.
- rd  in  REG_ADDR_W  rd field.
- out_valid  out  1  EX/MEM outputs are valid.
- out_ready  in  1  EX/MEM consumes the outputs.
- alu_result  out  DATA_W  registered ALU result.
- zero  out  1  registered, alu_result == 0.
- branch_target  out  DATA_W  registered last_pc + (immediate << 2).
- read_data2_out  out  DATA_W  registered read_data2 (store data).
- dest_reg  out  REG_ADDR_W  registered rt/rd mux output.
- busy  out  1  MULT/DIV iteration in progress.

Behaviour:
- Reset (async, rst=1): every output 0; state IDLE; HI=LO=0; iteration counter 0. Asserting rst mid-MULT/DIV aborts it and discards the partial result.
- Handshake:
  - Accept = in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Output register loads on accept of a single-cycle op; latency 1 cycle.
  - While out_valid && !out_ready, all outputs hold stable.
  - out_valid drops the cycle after out_ready unless a new accept loads it in the same cycle (back-to-back, 1 instruction/cycle).
- alu_op decode:
  - 000 add; 001 sub; 010 R-type by funct; 011 and; 100 or; 101 slt; 110/111 add.
- R-type funct decode:
  - 0x20 add; 0x22 sub; 0x24 and; 0x25 or; 0x27 nor; 0x2A slt (signed).
  - 0x00 sll, 0x02 srl, 0x03 sra, shifting operand 2 by shamt.
  - 0x10 mfhi; 0x12 mflo.
  - 0x18 mult; 0x1A div.
  - Any other funct -> result 0.
- Arithmetic: add/sub wrap modulo 2^DATA_W with no overflow trap; slt result is 1 or 0.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL on accept of funct 0x18; IDLE -> DIV on accept of funct 0x1A.
  - MUL/DIV each run exactly DATA_W iterations (shift-add / restoring), signed via operand magnitudes and sign correction. busy=1 throughout.
  - After the last iteration: {HI,LO} = 2*DATA_W-bit product; for div, LO = quotient (truncating toward zero) and HI = remainder (sign of dividend). Then -> DONE.
  - DONE: load output register with alu_result=0, dest_reg=0, zero=1, out_valid=1 (keeps ordering downstream); -> IDLE.
  - DONE waits while the output register is still occupied and not consumed.
  - Divide by zero: no iterations; LO = all ones, HI = dividend; IDLE -> DONE next cycle.
- mfhi/mflo immediately after mult/div: blocked by in_ready=0 until DONE, so they always see final HI/LO.
- Total mult/div latency, accept to out_valid: DATA_W+2 cycles.
- branch_target is computed for every instruction; its use is decided downstream.

Optional Feature:
- MULDIV_EN defined: MULT/DIV unit, HI/LO registers, MUL/DIV/DONE states and busy behave as above.
- MULDIV_EN undefined: funct 0x18/0x1A/0x10/0x12 decode as unsupported (result 0, single-cycle); no HI/LO storage; FSM reduced to IDLE; busy tied 0.

Test Plan:
- alu_op=010, funct=0x20, rd1=5, rd2=7, reg_dst=1, rd=3 -> next cycle out_valid=1, alu_result=12, zero=0, dest_reg=3.
- alu_op=001, rd1=rd2=0x1234, last_pc=0x100, immediate=0xFFFFFFFF -> alu_result=0, zero=1, branch_target=0xFC.
- out_ready=0 for 3 cycles with in_valid=1 streaming -> in_ready=0 and outputs frozen; release -> one result per cycle, none lost or duplicated.
- MULDIV_EN set: mult rd1=-3, rd2=7, then mflo, then mfhi -> in_ready low 34 cycles, then mflo=0xFFFFFFEB, mfhi=0xFFFFFFFF.
- div rd1=-7, rd2=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; div by 0 with rd1=9 -> LO=0xFFFFFFFF, HI=9 within 2 cycles.
- rst pulsed at iteration 10 of a mult -> all outputs 0, busy=0, HI=LO=0, in_ready=1 after rst release.
